uart_frame_ctrl: RTL and testbench

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

---
 rtl/uart_frame_ctrl.sv | 113 +++++++++++
 tb/tb_uart_frame_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// UART command-frame parser: collects opcode, 24-bit address and optional 32-bit
// write data from a byte stream and presents one DDR command with valid/ready.
module uart_frame_ctrl #(
  parameter int         TIMEOUT_CYC = 1000,
  parameter logic [7:0] OP_WR       = 8'hA5,
  parameter logic [7:0] OP_RD       = 8'h5A
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_cmd_ready,
  output logic        o_cmd_valid,
  output logic        o_cmd_we,
  output logic [23:0] o_cmd_addr,
  output logic [31:0] o_cmd_wdata,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;

  localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
  // Fires on the idle cycle that would bring the count up to TIMEOUT_CYC.
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    state_reg;
  logic [1:0]    byte_cnt_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic          we_reg;
  logic [23:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic          err_reg;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg    <= ST_IDLE;
      byte_cnt_reg <= 2'd0;
      tmo_cnt_reg  <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= 24'd0;
      wdata_reg    <= 32'd0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == OP_WR || i_rx_data == OP_RD) begin
              we_reg       <= (i_rx_data == OP_WR);
              byte_cnt_reg <= 2'd0;
              tmo_cnt_reg  <= '0;
              state_reg    <= ST_ADDR;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end

        ST_ADDR, ST_DATA: begin
          // An arriving byte always takes priority over a coincident timeout.
          if (i_rx_valid) begin
            tmo_cnt_reg <= '0;
            if (state_reg == ST_ADDR) begin
              addr_reg <= {addr_reg[15:0], i_rx_data};
              if (byte_cnt_reg == 2'd2) begin
                byte_cnt_reg <= 2'd0;
                state_reg    <= we_reg ? ST_DATA : ST_ISSUE;
              end else begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
              end
            end else begin
              wdata_reg <= {wdata_reg[23:0], i_rx_data};
              if (byte_cnt_reg == 2'd3) begin
                byte_cnt_reg <= 2'd0;
                state_reg    <= ST_ISSUE;
              end else begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
              end
            end
          end else if (tmo_cnt_reg == TMO_LAST) begin
            tmo_cnt_reg <= '0;
            err_reg     <= 1'b1;
            state_reg   <= ST_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
          end
        end

        default: begin
          // ISSUE: payload is frozen; any byte here is an overrun and is dropped.
          if (i_rx_valid) begin
            err_reg <= 1'b1;
          end
          if (i_cmd_ready) begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_cmd_valid = (state_reg == ST_ISSUE);
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_cmd_we    = we_reg;
  assign o_cmd_addr  = addr_reg;
  assign o_cmd_wdata = wdata_reg;
  assign o_err       = err_reg;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: write/read frames, bad opcode, timeout,
// overrun and mid-frame reset, all with hand-computed expectations.
module tb_uart_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic        cmd_we;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_frame_ctrl #(
    .TIMEOUT_CYC(8),
    .OP_WR      (8'hA5),
    .OP_RD      (8'h5A)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .i_cmd_ready(cmd_ready),
    .o_cmd_valid(cmd_valid),
    .o_cmd_we   (cmd_we),
    .o_cmd_addr (cmd_addr),
    .o_cmd_wdata(cmd_wdata),
    .o_busy     (busy),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(cmd_valid), 64'd0);
    check({tag, "_we"},    64'(cmd_we),    64'd0);
    check({tag, "_addr"},  64'(cmd_addr),  64'd0);
    check({tag, "_wdata"}, 64'(cmd_wdata), 64'd0);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_err"},   64'(err),       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wr_frame [8];
    int         vcnt;
    wr_frame = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    // Reset state
    #3 rst = 1'b0;
    tick(); tick();
    check_all_zero("rst");
    rst = 1'b1;
    tick();
    check("rst_rel_busy", 64'(busy), 64'd0);

    // Write frame with ready held high (ready ignored outside ISSUE)
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_byte(wr_frame[i]);
      if (i == 3) check("wr_busy_mid", 64'(busy), 64'd1);
      if (i == 6) check("wr_valid_early", 64'(cmd_valid), 64'd0);
    end
    check("wr_valid", 64'(cmd_valid), 64'd1);
    check("wr_we",    64'(cmd_we),    64'd1);
    check("wr_addr",  64'(cmd_addr),  64'h123456);
    check("wr_wdata", 64'(cmd_wdata), 64'hDEADBEEF);
    tick();
    check("wr_valid_drop", 64'(cmd_valid), 64'd0);
    check("wr_busy_idle",  64'(busy),      64'd0);

    // Read frame, ready low for 5 valid cycles then high
    cmd_ready = 1'b0;
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    check("rd_we",   64'(cmd_we),   64'd0);
    check("rd_addr", 64'(cmd_addr), 64'h000010);
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_valid) vcnt++;
      tick();
    end
    cmd_ready = 1'b1;
    if (cmd_valid) vcnt++;
    tick();
    cmd_ready = 1'b0;
    check("rd_valid_cycles", 64'(vcnt), 64'd6);
    check("rd_valid_drop",   64'(cmd_valid), 64'd0);
    check("rd_busy_idle",    64'(busy),      64'd0);

    // Bad opcode
    send_byte(8'h3C);
    check("bad_err",   64'(err),       64'd1);
    check("bad_busy",  64'(busy),      64'd0);
    check("bad_valid", 64'(cmd_valid), 64'd0);
    tick();
    check("bad_err_pulse", 64'(err), 64'd0);

    // Byte arriving on the cycle the timeout would fire wins
    send_byte(8'hA5);
    for (int i = 0; i < 7; i++) tick();
    send_byte(8'h11);
    check("tmo_race_err",  64'(err),  64'd0);
    check("tmo_race_busy", 64'(busy), 64'd1);

    // Timeout after exactly 8 idle cycles
    for (int i = 0; i < 7; i++) tick();
    check("tmo_7_busy", 64'(busy), 64'd1);
    check("tmo_7_err",  64'(err),  64'd0);
    tick();
    check("tmo_8_err",  64'(err),  64'd1);
    check("tmo_8_busy", 64'(busy), 64'd0);
    tick();
    check("tmo_err_pulse", 64'(err), 64'd0);
    cmd_ready = 1'b1;
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    check("tmo_next_valid", 64'(cmd_valid), 64'd1);
    check("tmo_next_addr",  64'(cmd_addr),  64'h000001);
    check("tmo_next_we",    64'(cmd_we),    64'd0);
    check("tmo_next_err",   64'(err),       64'd0);
    tick();
    check("tmo_next_done", 64'(cmd_valid), 64'd0);

    // Overrun while waiting, then overrun coincident with ready
    cmd_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("ovr_valid", 64'(cmd_valid), 64'd1);
    send_byte(8'h77);
    check("ovr_err",   64'(err),       64'd1);
    check("ovr_valid_held", 64'(cmd_valid), 64'd1);
    check("ovr_addr",  64'(cmd_addr),  64'h010203);
    check("ovr_wdata", 64'(cmd_wdata), 64'h11223344);
    check("ovr_we",    64'(cmd_we),    64'd1);
    tick();
    check("ovr_err_pulse", 64'(err), 64'd0);
    cmd_ready = 1'b1;
    send_byte(8'h77);
    cmd_ready = 1'b0;
    check("ovr_acc_err",   64'(err),       64'd1);
    check("ovr_acc_valid", 64'(cmd_valid), 64'd0);
    check("ovr_acc_busy",  64'(busy),      64'd0);

    // Reset mid-frame clears everything immediately
    tick();
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    tick();
    #2 rst = 1'b1;
    tick();
    check("mid_rel_err",  64'(err),  64'd0);
    check("mid_rel_busy", 64'(busy), 64'd0);
    cmd_ready = 1'b1;
    send_byte(8'h5A); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    check("mid_next_valid", 64'(cmd_valid), 64'd1);
    check("mid_next_addr",  64'(cmd_addr),  64'hABCDEF);
    check("mid_next_we",    64'(cmd_we),    64'd0);
    tick();
    check("mid_next_done", 64'(cmd_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
